seq_multiplier: RTL and testbench

//  Parametrised sequential shift-add multiplier; successor to the 4-bit combinational multiplier.

---
 rtl/seq_multiplier.sv | 110 +++++++++++
 tb/tb_seq_multiplier.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, unsigned or two's complement.
// Operands are latched on an accepted start; the product appears with a one-cycle done pulse.
module seq_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               a_neg, b_neg;
    logic [WIDTH:0]     ext_a, ext_b;
    logic [WIDTH:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0] acc_sum;

    // One extra magnitude bit keeps |-2^(WIDTH-1)| exact.
    always_comb begin
        a_neg = signed_mode & a[WIDTH-1];
        b_neg = signed_mode & b[WIDTH-1];
        ext_a = {a_neg, a};
        ext_b = {b_neg, b};
        mag_a = a_neg ? (~ext_a + 1'b1) : ext_a;
        mag_b = b_neg ? (~ext_b + 1'b1) : ext_b;
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        product_d = product_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{(WIDTH-1){1'b0}}, mag_a};
                    mplier_d = mag_b;
                    neg_d    = a_neg ^ b_neg;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Final iteration folds its partial product straight into the result.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d   = S_DONE;
                    product_d = neg_q ? (~acc_sum + 1'b1) : acc_sum;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: WIDTH=4 and WIDTH=8 instances, queue scoreboards checked on done.
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic        start4 = 1'b0, sm4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4;
    logic [7:0]  prod4;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] prod8;

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  exp4_q[$];
    logic [15:0] exp8_q[$];

    logic        rst_at_edge = 1'b0;
    logic [7:0]  prev4;
    logic [15:0] prev8;

    always @(posedge clk) rst_at_edge <= rst_n;

    function automatic longint ref_mul(int w, longint av, longint bv, bit s);
        longint x, y, p;
        x = av;
        y = bv;
        if (s && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
        if (s && y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
        p = x * y;
        return p & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Scoreboard + product-hold monitors
    always @(negedge clk) begin : mon4
        logic [7:0] e;
        if (done4) begin
            checks++;
            if (exp4_q.size() == 0) begin
                failures++;
                $display("FAIL w4_unexpected_done product=%h expected=none", prod4);
            end else begin
                e = exp4_q.pop_front();
                if (prod4 !== e) begin
                    failures++;
                    $display("FAIL w4_product got=%h expected=%h", prod4, e);
                end
            end
        end else if (rst_at_edge) begin
            checks++;
            if (prod4 !== prev4) begin
                failures++;
                $display("FAIL w4_product_hold got=%h expected=%h", prod4, prev4);
            end
        end
        prev4 = prod4;
    end

    always @(negedge clk) begin : mon8
        logic [15:0] e;
        if (done8) begin
            checks++;
            if (exp8_q.size() == 0) begin
                failures++;
                $display("FAIL w8_unexpected_done product=%h expected=none", prod8);
            end else begin
                e = exp8_q.pop_front();
                if (prod8 !== e) begin
                    failures++;
                    $display("FAIL w8_product got=%h expected=%h", prod8, e);
                end
            end
        end else if (rst_at_edge) begin
            checks++;
            if (prod8 !== prev8) begin
                failures++;
                $display("FAIL w8_product_hold got=%h expected=%h", prod8, prev8);
            end
        end
        prev8 = prod8;
    end

    task automatic issue4(input logic [3:0] av, input logic [3:0] bv, input logic s,
                          input logic [7:0] ev, input bit track);
        @(negedge clk);
        a4 = av; b4 = bv; sm4 = s; start4 = 1'b1;
        if (track) exp4_q.push_back(ev);
    endtask

    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic s,
                          input logic [15:0] ev);
        @(negedge clk);
        a8 = av; b8 = bv; sm8 = s; start8 = 1'b1;
        exp8_q.push_back(ev);
    endtask

    task automatic wait_done4(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) start4 = 1'b0;
            if (done4) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_done8(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) start8 = 1'b0;
            if (done8) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy4, done4, prod4} !== 10'd0) begin
            failures++;
            $display("FAIL reset_w4 got busy=%b done=%b product=%h expected 0 0 00", busy4, done4, prod4);
        end
        checks++;
        if ({busy8, done8, prod8} !== 18'd0) begin
            failures++;
            $display("FAIL reset_w8 got busy=%b done=%b product=%h expected 0 0 0000", busy8, done8, prod8);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned_basic();
        issue4(4'd3, 4'd2, 1'b0, 8'd6, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start4 = 1'b0;
            checks++;
            if (busy4 !== 1'b1 || done4 !== 1'b0) begin
                failures++;
                $display("FAIL basic_busy_cycle%0d got busy=%b done=%b expected busy=1 done=0", i, busy4, done4);
            end
        end
        @(negedge clk);
        checks++;
        if (done4 !== 1'b1 || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got busy=%b done=%b expected busy=0 done=1", busy4, done4);
        end
        @(negedge clk);
        checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle got busy=%b done=%b expected busy=0 done=0", busy4, done4);
        end
    endtask

    task automatic test_unsigned_bounds();
        logic [3:0] av [3] = '{4'd15, 4'd15, 4'd0};
        logic [3:0] bv [3] = '{4'd1, 4'd15, 4'd13};
        logic [7:0] ev [3] = '{8'd15, 8'd225, 8'd0};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            issue4(av[i], bv[i], 1'b0, ev[i], 1'b1);
            wait_done4(cyc);
            checks++;
            if (cyc != 5) begin
                failures++;
                $display("FAIL bounds_latency op%0d got=%0d expected=5", i, cyc);
            end
            @(negedge clk);
            checks++;
            if (done4 !== 1'b0) begin
                failures++;
                $display("FAIL bounds_done_width op%0d got done=%b expected=0", i, done4);
            end
        end
    endtask

    task automatic test_signed();
        logic [3:0] av [4] = '{4'hD, 4'h8, 4'h8, 4'h7};
        logic [3:0] bv [4] = '{4'h5, 4'h8, 4'h7, 4'hF};
        logic [7:0] ev [4] = '{8'hF1, 8'h40, 8'hC8, 8'hF9};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            issue4(av[i], bv[i], 1'b1, ev[i], 1'b1);
            wait_done4(cyc);
            checks++;
            if (cyc != 5) begin
                failures++;
                $display("FAIL signed_latency op%0d got=%0d expected=5", i, cyc);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_handshake();
        int cyc;
        // start held high; operands change while running
        issue4(4'd5, 4'd3, 1'b0, 8'd15, 1'b1);
        @(negedge clk);
        a4 = 4'hE; b4 = 4'h3; sm4 = 1'b1;
        checks++;
        if (busy4 !== 1'b1) begin
            failures++;
            $display("FAIL held_busy got=%b expected=1", busy4);
        end
        cyc = -1;
        for (int i = 2; i <= 21; i++) begin
            @(negedge clk);
            if (done4) begin
                cyc = i;
                break;
            end
        end
        checks++;
        if (cyc != 5) begin
            failures++;
            $display("FAIL held_latency got=%0d expected=5", cyc);
        end
        exp4_q.push_back(8'hFA);
        wait_done4(cyc);
        checks++;
        if (cyc != 5) begin
            failures++;
            $display("FAIL held_second_latency got=%0d expected=5", cyc);
        end
        // explicit back-to-back restart during DONE
        issue4(4'hD, 4'h5, 1'b1, 8'hF1, 1'b1);
        wait_done4(cyc);
        checks++;
        if (cyc != 5) begin
            failures++;
            $display("FAIL b2b_first_latency got=%0d expected=5", cyc);
        end
        a4 = 4'h6; b4 = 4'hE; sm4 = 1'b1; start4 = 1'b1;
        exp4_q.push_back(8'hF4);
        wait_done4(cyc);
        checks++;
        if (cyc != 5) begin
            failures++;
            $display("FAIL b2b_second_latency got=%0d expected=5", cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int dones;
        issue4(4'd7, 4'd7, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'd0) begin
            failures++;
            $display("FAIL midrun_reset got busy=%b done=%b product=%h expected 0 0 00", busy4, done4, prod4);
        end
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done4) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL midrun_no_done got=%0d pulses expected=0", dones);
        end
    endtask

    task automatic test_width8();
        int cyc;
        logic [7:0] av, bv;
        logic s;
        issue8(8'd255, 8'd255, 1'b0, 16'hFE01);
        wait_done8(cyc);
        checks++;
        if (cyc != 9) begin
            failures++;
            $display("FAIL w8_latency_max got=%0d expected=9", cyc);
        end
        issue8(8'h80, 8'h80, 1'b1, 16'h4000);
        wait_done8(cyc);
        checks++;
        if (cyc != 9) begin
            failures++;
            $display("FAIL w8_latency_minsq got=%0d expected=9", cyc);
        end
        for (int n = 0; n < 200; n++) begin
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(0, 255));
            s  = 1'($urandom_range(0, 1));
            if (n % 25 == 0) av = '0;
            if (n % 25 == 7) bv = '0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue8(av, bv, s, 16'(ref_mul(8, longint'(av), longint'(bv), s)));
            wait_done8(cyc);
            checks++;
            if (cyc != 9) begin
                failures++;
                $display("FAIL w8_rand_latency op%0d got=%0d expected=9", n, cyc);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned_basic();
        test_unsigned_bounds();
        test_signed();
        test_handshake();
        test_reset_mid_run();
        test_width8();
        repeat (2) @(negedge clk);
        checks++;
        if (exp4_q.size() != 0) begin
            failures++;
            $display("FAIL w4_pending got=%0d expected=0", exp4_q.size());
        end
        checks++;
        if (exp8_q.size() != 0) begin
            failures++;
            $display("FAIL w8_pending got=%0d expected=0", exp8_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
